// File: rtl/counter_sched_pkg.sv
// Shared types for the counter scheduler: FSM state encoding and default counter width.
// Pure declarations; no latency or backpressure of its own.
package counter_sched_pkg;

    localparam int COUNTER_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_scheduler_rr_arbiter2.sv
// Two-way arbiter, combinational one-hot grant; round-robin pointer when COUNTER_SCHED_RR_EN is set, else fixed priority to 0.
// Zero latency; the pointer only moves on an advance with a live grant.
module rr_arbiter2
    import counter_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef COUNTER_SCHED_RR_EN
    logic prio;

    always_comb begin
        grant = 2'b00;
        if (prio == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    // After granting requester 0 the pointer favours 1, and vice versa.
    always_ff @(posedge clk) begin
        if (reset)
            prio <= 1'b0;
        else if (advance && (grant != 2'b00))
            prio <= grant[0];
    end
`else
    wire unused_ok = &{1'b0, clk, reset, advance};

    always_comb begin
        grant = 2'b00;
        if (req[0])      grant = 2'b01;
        else if (req[1]) grant = 2'b10;
    end
`endif

endmodule

// File: rtl/counter_scheduler.sv
// Schedules count jobs from two requesters onto one shared up/down counter; arbitration policy set by COUNTER_SCHED_RR_EN.
// done arrives 3+N cycles after accept; req_ready is held low whenever a job is in flight.
module counter_scheduler
    import counter_sched_pkg::*;
#(
    parameter int W = COUNTER_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_start,
    input  logic [2*W-1:0] req_target,
    input  logic [1:0]     req_down,
    output logic           cnt_en,
    output logic           cnt_load,
    output logic           cnt_mode,
    output logic [W-1:0]   cnt_din,
    input  logic [W-1:0]   cnt_q,
    output logic           busy,
    output logic           done,
    output logic           done_id
);

    state_t         state;
    logic [W-1:0]   start_q;
    logic [W-1:0]   target_q;
    logic           down_q;
    logic           id_q;
    logic [1:0]     grant;
    logic           accept;
    logic           win;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = ((state == IDLE) && !reset) ? grant : 2'b00;
    assign accept    = |(req_ready & req_valid);
    assign win       = req_ready[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= '0;
            target_q <= '0;
            down_q   <= 1'b0;
            id_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        start_q  <= win ? req_start[2*W-1:W]  : req_start[W-1:0];
                        target_q <= win ? req_target[2*W-1:W] : req_target[W-1:0];
                        down_q   <= req_down[win];
                        id_q     <= win;
                        state    <= LOAD;
                    end
                end
                LOAD: state <= RUN;
                RUN: begin
                    if (cnt_q == target_q)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The terminal compare is live on cnt_q so the step that reaches target is the last one issued.
    always_comb begin
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_mode = 1'b0;
        cnt_din  = '0;
        case (state)
            LOAD: begin
                cnt_en   = 1'b1;
                cnt_load = 1'b1;
                cnt_din  = start_q;
            end
            RUN: begin
                if (cnt_q != target_q) begin
                    cnt_en   = 1'b1;
                    cnt_mode = down_q;
                end
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign done_id = done & id_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler with a behavioural shared counter and a job-level latency/arbitration model.
// Honours COUNTER_SCHED_RR_EN for the expected grant order.
module tb_counter_scheduler;
    import counter_sched_pkg::*;

    localparam int W   = COUNTER_W;
    localparam int MOD = 1 << W;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_start;
    logic [2*W-1:0] req_target;
    logic [1:0]     req_down;
    logic           cnt_en, cnt_load, cnt_mode;
    logic [W-1:0]   cnt_din;
    logic [W-1:0]   cnt_q = '0;
    logic           busy, done, done_id;

    int checks   = 0;
    int failures = 0;
    int model_prio = 0;

    always #5 clk = ~clk;

    counter_scheduler #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_start  (req_start),
        .req_target (req_target),
        .req_down   (req_down),
        .cnt_en     (cnt_en),
        .cnt_load   (cnt_load),
        .cnt_mode   (cnt_mode),
        .cnt_din    (cnt_din),
        .cnt_q      (cnt_q),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id)
    );

    // Shared up/down counter the scheduler drives.
    always @(posedge clk) begin
        if (cnt_en) begin
            if (cnt_load)      cnt_q <= cnt_din;
            else if (cnt_mode) cnt_q <= cnt_q - 1'b1;
            else               cnt_q <= cnt_q + 1'b1;
        end
    end

    function automatic int exp_winner(input logic [1:0] v);
`ifdef COUNTER_SCHED_RR_EN
        if (v == 2'b11) return model_prio;
`endif
        return v[0] ? 0 : 1;
    endfunction

    function automatic logic [1:0] onehot(input int idx);
        return (idx == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        reset      = 1'b0;
        model_prio = 0;
    endtask

    // Issues one job, scrambles the inputs after accept, follows it to done; keep = valid bits held while busy.
    task automatic do_job(input logic [1:0] vld, input logic [1:0] keep,
                          input logic [W-1:0] s0, input logic [W-1:0] t0,
                          input logic [W-1:0] s1, input logic [W-1:0] t1,
                          input logic [1:0] dn, output int got_id, output int done_at);
        int w, n, en_cnt;
        logic [W-1:0] s, t;
        logic d;
        logic [1:0] exp_rdy;
        req_start  = {s1, s0};
        req_target = {t1, t0};
        req_down   = dn;
        req_valid  = vld;
        #1;
        w = exp_winner(vld);
        s = (w == 1) ? s1 : s0;
        t = (w == 1) ? t1 : t0;
        d = dn[w];
        n = d ? ((int'(s) - int'(t) + MOD) % MOD) : ((int'(t) - int'(s) + MOD) % MOD);
        checks++;
        if (req_ready !== onehot(w))
            $display("FAIL grant: req_ready=%b expected=%b (valid=%b)", req_ready, onehot(w), vld);
        if (req_ready !== onehot(w)) failures++;

        @(posedge clk); #1;
        model_prio = 1 - w;
        req_valid  = keep;
        req_start  = 2*W'($urandom);
        req_target = 2*W'($urandom);
        req_down   = 2'($urandom);
        en_cnt  = 0;
        done_at = -1;
        got_id  = -1;
        for (int j = 0; j < 40; j++) begin
            if (cnt_en === 1'b1) en_cnt++;
            if (j == 0) begin
                checks++;
                if (!(cnt_en === 1'b1 && cnt_load === 1'b1 && cnt_din === s)) begin
                    failures++;
                    $display("FAIL load: en=%b load=%b din=%0d expected en=1 load=1 din=%0d", cnt_en, cnt_load, cnt_din, s);
                end
            end else if (cnt_en === 1'b1) begin
                checks++;
                if (cnt_mode !== d || cnt_load !== 1'b0) begin
                    failures++;
                    $display("FAIL step: mode=%b load=%b expected mode=%b load=0 (j=%0d)", cnt_mode, cnt_load, d, j);
                end
            end
            checks++;
            if (req_ready !== 2'b00 || busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_block: req_ready=%b busy=%b expected 00 and 1 (j=%0d)", req_ready, busy, j);
            end
            if (done === 1'b1) begin
                done_at = j;
                got_id  = int'(done_id);
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done_at != 2 + n) begin
            failures++;
            $display("FAIL done_latency: done after %0d edges, expected %0d (N=%0d, -1 means timeout)", done_at, 2 + n, n);
        end
        checks++;
        if (got_id != w) begin
            failures++;
            $display("FAIL done_id: got %0d expected %0d", got_id, w);
        end
        checks++;
        if (en_cnt != n + 1) begin
            failures++;
            $display("FAIL en_cycles: cnt_en high %0d cycles, expected %0d", en_cnt, n + 1);
        end

        @(posedge clk); #1;
        exp_rdy = (keep == 2'b00) ? 2'b00 : onehot(exp_winner(keep));
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL after_done: done=%b busy=%b req_ready=%b expected 0 0 %b", done, busy, req_ready, exp_rdy);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_start  = '0;
        req_target = '0;
        req_down   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        model_prio = 0;
        #1;
        checks++;
        if ({busy, done, done_id} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status: busy/done/done_id=%b expected 000", {busy, done, done_id});
        end
        checks++;
        if ({cnt_en, cnt_load, cnt_mode, cnt_din, req_ready} !== '0) begin
            failures++;
            $display("FAIL reset_cnt: en=%b load=%b mode=%b din=%0d ready=%b expected all 0",
                     cnt_en, cnt_load, cnt_mode, cnt_din, req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int id, at;
        do_job(2'b01, 2'b00, 4'd3, 4'd6, 4'd0, 4'd0, 2'b00, id, at);
        checks++;
        if (at != 5 || id != 0) begin
            failures++;
            $display("FAIL up_3_6: done at T+%0d id=%0d expected T+6 id=0", at + 1, id);
        end
        do_job(2'b10, 2'b00, 4'd0, 4'd0, 4'd2, 4'd14, 2'b10, id, at);
        checks++;
        if (at != 6 || id != 1) begin
            failures++;
            $display("FAIL down_wrap: done at T+%0d id=%0d expected T+7 id=1", at + 1, id);
        end
        do_job(2'b01, 2'b00, 4'd9, 4'd9, 4'd0, 4'd0, 2'b00, id, at);
        checks++;
        if (at != 2) begin
            failures++;
            $display("FAIL zero_steps: done at T+%0d expected T+3", at + 1);
        end
    endtask

    task automatic test_arbitration();
        int id0, id1, at, exp1;
        apply_reset();
        do_job(2'b11, 2'b00, 4'd1, 4'd4, 4'd7, 4'd5, 2'b00, id0, at);
        do_job(2'b11, 2'b00, 4'd1, 4'd4, 4'd7, 4'd5, 2'b00, id1, at);
`ifdef COUNTER_SCHED_RR_EN
        exp1 = 1;
`else
        exp1 = 0;
`endif
        checks++;
        if (id0 != 0 || id1 != exp1) begin
            failures++;
            $display("FAIL grant_order: got %0d then %0d expected 0 then %0d", id0, id1, exp1);
        end
    endtask

    task automatic test_reset_mid_run();
        int id, at;
        apply_reset();
        req_start  = {4'd0, 4'd0};
        req_target = {4'd0, 4'd10};
        req_down   = 2'b00;
        req_valid  = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        model_prio = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b done=%b cnt_en=%b expected 0 0 0", busy, done, cnt_en);
        end
        do_job(2'b10, 2'b00, 4'd0, 4'd0, 4'd5, 4'd3, 2'b10, id, at);
    endtask

    task automatic test_busy_hold();
        int id, at;
        do_job(2'b01, 2'b10, 4'd12, 4'd1, 4'd3, 4'd3, 2'b00, id, at);
    endtask

    task automatic test_random();
        int id, at;
        logic [1:0] v;
        for (int k = 0; k < 12; k++) begin
            v = 2'($urandom_range(1, 3));
            do_job(v, 2'b00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), id, at);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_arbitration();
        test_reset_mid_run();
        test_busy_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 Parameter: W, 4, count and operand width in bits; SHALL match the shared up/down counter width.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: reset  in  1  reset, synchronous and active-high.
REQ-004 Port: req_valid  in  2  per-requester job request, bit i = requester i.
REQ-005 Port: req_ready  out  2  per-requester accept; job i transfers when req_valid[i] and req_ready[i] are both high on a clk edge.
REQ-006 Port: req_start  in  2*W  start value; bits [i*W +: W] belong to requester i.
REQ-007 Port: req_target  in  2*W  terminal value; bits [i*W +: W] belong to requester i.
REQ-008 Port: req_down  in  2  direction: 1 = count down, 0 = count up.
REQ-009 Port: cnt_en, cnt_load, cnt_mode  out  1 each  drive the counter's enable, load and mode inputs.
REQ-010 Port: cnt_din  out  W  counter load data.
REQ-011 Port: cnt_q  in  W  counter output.
REQ-012 Port: busy  out  1  high whenever the state is not IDLE.
REQ-013 Port: done  out  1  one-cycle completion pulse.
REQ-014 Port: done_id  out  1  requester that owned the finished job, valid while done is high.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
REQ-016 In IDLE, req_ready SHALL be one-hot to the arbitration winner among the asserted req_valid bits (combinational), and zero when no request is pending.
REQ-017 In all states other than IDLE, req_ready SHALL be 0.
REQ-018 On accept, the block SHALL latch the winner's start, target, direction and id, then move to LOAD.
REQ-019 In LOAD, the outputs SHALL be cnt_en=1, cnt_load=1 and cnt_din=latched start, and the next state SHALL be RUN.
REQ-020 In RUN with cnt_q != target, the outputs SHALL be cnt_en=1, cnt_load=0 and cnt_mode=latched direction, and the state SHALL stay RUN.
REQ-021 In RUN with cnt_q == target, cnt_en SHALL be 0 and the next state SHALL be DONE.
REQ-022 In DONE, done SHALL be 1 and done_id SHALL be the latched id for exactly one cycle, and the next state SHALL be IDLE.
REQ-023 Outside LOAD and RUN-enabled cycles, cnt_en, cnt_load, cnt_mode and cnt_din SHALL all be 0.
REQ-024 Counting wraps modulo 2^W: up counting goes 15->0 and down counting goes 0->15 at W=4. The target is always reached, so no timeout exists.
REQ-025 For a job accepted on edge T, done SHALL be high in cycle T+3+N, where N = (target-start) mod 2^W for up counting and (start-target) mod 2^W for down counting.
REQ-026 When start == target, N SHALL be 0 and no count step SHALL be issued.
REQ-027 An accepted requester's later changes to its inputs SHALL NOT affect the running job.

Reset
REQ-028 While reset is high, the state SHALL return to IDLE on the next clk edge from any state, including mid-RUN, with no done pulse.
REQ-029 After reset, busy, done, done_id, req_ready and all cnt_* outputs SHALL be 0, and the arbitration pointer SHALL give priority to requester 0.
REQ-030 This block SHALL NOT drive the counter's own reset; after an aborted job the counter value is left unspecified and the next job reloads it.

Configuration
REQ-031 With COUNTER_SCHED_RR_EN defined, arbitration SHALL be round-robin: after each accept, the pointer gives priority to the non-granted requester.
REQ-032 With COUNTER_SCHED_RR_EN undefined, arbitration SHALL be fixed priority with requester 0 winning and no pointer state.

Structure
REQ-033 Package counter_sched_pkg SHALL hold the state enum (IDLE, LOAD, RUN, DONE) and the default width constant COUNTER_W = 4.
REQ-034 Arbitration SHALL live in a sub-module named rr_arbiter2 (2 requests in, one-hot grant out, advance input, macro-controlled policy).

Verification
REQ-035 req_valid=01, start=3, target=6, up: accept at T; LOAD at T+1; cnt_en high T+2..T+4; done=1 with done_id=0 at T+6.
REQ-036 Requester 1, start=2, target=14, down: the counter wraps 0->15 and done arrives at T+3+4 = T+7.
REQ-037 start=target=9: cnt_en pulses only in LOAD, and done arrives at T+3.
REQ-038 req_valid=11 held for two jobs: with the macro, grants go 0 then 1; without it, grants go 0 then 0.
REQ-039 reset asserted for one cycle during RUN: the state is IDLE after the edge, there is no done pulse, busy=0, and a new request is accepted the following cycle.
REQ-040 req_valid asserted while busy: req_ready stays 0 until the cycle after done.
